id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline register for the 23-bit MIPS pipeline, with integrated load-use hazard detection, bubble insertion and branch flush.
- Sits directly upstream of the EX-stage forwarding unit. Its ex_rs/ex_rt outputs are the EX-stage source register numbers that the forwarding unit compares against MEM/WB destinations.
- Produces stall_out, which holds the PC and the IF/ID register.

Parameters:
- DATA_W, 23, datapath width (register data, immediate)
- REG_AW, 5, register address width
- CTRL_W, 8, control bundle width: {RegWrite, MemRead, MemWrite, MemToReg, ALUSrc, ALUOp[2:0]}, MSB first
- CNT_W, 16, bubble counter width

Ports:
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID holds a real instruction
- id_rs  in  REG_AW  source register 1
- id_rt  in  REG_AW  source register 2
- id_rd  in  REG_AW  destination register, already muxed rt/rd in ID
- id_uses_rt  in  1  instruction reads rt as an operand
- id_rs_data  in  DATA_W  register file read data 1
- id_rt_data  in  DATA_W  register file read data 2
- id_imm  in  DATA_W  sign-extended immediate
- id_ctrl  in  CTRL_W  decoded control bundle
- flush  in  1  branch or jump resolved taken; kill the ID instruction
- ex_valid  out  1  EX-stage instruction valid
- ex_rs  out  REG_AW  registered id_rs
- ex_rt  out  REG_AW  registered id_rt
- ex_rd  out  REG_AW  registered id_rd
- ex_rs_data  out  DATA_W  registered id_rs_data
- ex_rt_data  out  DATA_W  registered id_rt_data
- ex_imm  out  DATA_W  registered id_imm
- ex_ctrl  out  CTRL_W  registered id_ctrl, zero when bubble
- stall_out  out  1  hold PC and IF/ID this cycle (combinational)
- bubble_cnt  out  CNT_W  saturating count of inserted bubbles

Behaviour:
- Reset (async, rst_n=0): all ex_* outputs = 0, ex_valid = 0, bubble_cnt = 0, FSM = RUN. stall_out is forced to 0 while rst_n=0. Reset asserted mid-stall aborts the stall; the FSM re-enters RUN.
- hazard (combinational) = id_valid & ex_valid & ex_ctrl.MemRead & (ex_rd != 0) & ((ex_rd == id_rs) | (id_uses_rt & (ex_rd == id_rt))).
- FSM states:
  - RUN: normal flow. On hazard & !flush: stall_out = 1, load a bubble, go to BUBBLE. Otherwise stay in RUN.
  - BUBBLE: the load has moved to MEM and ex_valid = 0, so hazard is necessarily 0. stall_out = 0. Load the ID instruction normally, return to RUN. BUBBLE lasts exactly one cycle.
- Bubble load: ex_valid <= 0 and ex_ctrl <= 0. ex_rs, ex_rt, ex_rd and the data fields are also cleared to 0, so the forwarding unit never matches a bubble.
- Normal load: every ex_* register takes the corresponding id_* value, and ex_valid <= id_valid. A register is loaded every cycle; there is no hold, because a stall only freezes upstream stages.
- flush has priority over hazard:
  - flush = 1 → bubble load, stall_out = 0, FSM = RUN.
  - bubble_cnt is not incremented on a flush.
- bubble_cnt increments by 1 on each hazard bubble and saturates at 2^CNT_W-1 with no wrap.
- Latency: one cycle from id_* to ex_*; a dependent instruction following a load loses exactly one cycle.
- Register 0 never triggers a stall.
- A hazard with id_valid = 0 does not stall.

Decomposition:
- Shared package pipe_pkg:
  - CTRL_W and the bit positions of the control bundle (CTRL_REGWRITE, CTRL_MEMREAD, etc.)
  - REG_AW and DATA_W defaults
  - FSM state encoding RUN = 1'b0, BUBBLE = 1'b1
- Sub-module load_use_detect: purely combinational hazard equation, unit-testable and reusable by a future branch-compare stall.

Test Plan:
1. Reset: assert rst_n=0 with arbitrary id_* and clk running → all ex_* = 0, stall_out = 0, bubble_cnt = 0; release → the first edge loads id_*.
2. Load-use: cycle N, EX = lw (MemRead=1, ex_rd=8), ID = add rs=8 → stall_out = 1 in N; after the edge ex_valid = 0, ex_ctrl = 0, bubble_cnt = 1. Cycle N+1, the same add → stall_out = 0; after the edge ex_rs = 8, ex_valid = 1.
3. No false stall:
   - lw ex_rd=8, ID I-type with rt=8 and id_uses_rt=0 → stall_out = 0.
   - lw with ex_rd=0, ID rs=0 → stall_out = 0.
   - Non-load (MemRead=0) with ex_rd=8, ID rs=8 → stall_out = 0.
4. Flush vs hazard: hazard condition as in test 2 plus flush = 1 → stall_out = 0; after the edge ex_valid = 0, bubble_cnt unchanged, FSM = RUN.
5. Reset mid-stall: assert rst_n=0 during the BUBBLE cycle → outputs cleared immediately (asynchronously), FSM = RUN.
6. Saturation: with CNT_W=2, force 5 consecutive lw/use pairs → bubble_cnt = 1, 2, 3, 3, 3.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the MIPS pipeline: control bundle layout, width defaults, ID/EX FSM encoding.
// No logic, no latency.
// No flow control; constants and types only.
package pipe_pkg;

  // Default datapath and register-address widths.
  localparam int DEF_DATA_W = 23;
  localparam int DEF_REG_AW = 5;

  // Control bundle: {RegWrite, MemRead, MemWrite, MemToReg, ALUSrc, ALUOp[2:0]}, MSB first.
  localparam int DEF_CTRL_W     = 8;
  localparam int CTRL_REGWRITE  = 7;
  localparam int CTRL_MEMREAD   = 6;
  localparam int CTRL_MEMWRITE  = 5;
  localparam int CTRL_MEMTOREG  = 4;
  localparam int CTRL_ALUSRC    = 3;
  localparam int CTRL_ALUOP_LSB = 0;
  localparam int CTRL_ALUOP_W   = 3;

  // ID/EX stall sequencer states.
  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_BUBBLE = 1'b1
  } idex_state_t;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detector: a load in EX whose destination is read by the valid ID instruction.
// Latency: purely combinational.
// No flow control; the caller decides whether to stall.
// Ports: id_valid/id_rs/id_rt/id_uses_rt describe the ID consumer, ex_valid/ex_memread/ex_rd the
// EX producer, hazard is the result.
module load_use_detect #(
  parameter int REG_AW = pipe_pkg::DEF_REG_AW
) (
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rt,
  input  logic              ex_valid,
  input  logic              ex_memread,
  input  logic [REG_AW-1:0] ex_rd,
  output logic              hazard
);

  logic rs_match;
  logic rt_match;

  // $zero is hardwired, so a load "writing" it never produces a real dependency.
  assign rs_match = (ex_rd == id_rs);
  assign rt_match = id_uses_rt && (ex_rd == id_rt);
  assign hazard   = id_valid && ex_valid && ex_memread && (ex_rd != '0) && (rs_match || rt_match);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion and taken-branch flush.
// Latency: one cycle id_* -> ex_*; a load-dependent instruction loses exactly one cycle.
// Backpressure: stall_out (combinational) freezes PC and IF/ID; this register itself never holds.
// Ports: clk/rst_n; id_* decoded ID instruction; flush kills it; ex_* registered EX view;
// stall_out upstream hold; bubble_cnt saturating count of load-use bubbles.
module id_ex_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_AW = DEF_REG_AW,
  parameter int CTRL_W = DEF_CTRL_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_uses_rt,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              flush,
  output logic              ex_valid,
  output logic [REG_AW-1:0] ex_rs,
  output logic [REG_AW-1:0] ex_rt,
  output logic [REG_AW-1:0] ex_rd,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [DATA_W-1:0] ex_imm,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic              stall_out,
  output logic [CNT_W-1:0]  bubble_cnt
);

  idex_state_t state;
  idex_state_t state_nxt;
  logic        hazard;
  logic        stall_int;
  logic        load_bubble;
  logic        cnt_inc;

  load_use_detect #(
    .REG_AW (REG_AW)
  ) u_detect (
    .id_valid   (id_valid),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_uses_rt (id_uses_rt),
    .ex_valid   (ex_valid),
    .ex_memread (ex_ctrl[CTRL_MEMREAD]),
    .ex_rd      (ex_rd),
    .hazard     (hazard)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: a flush always lands in RUN; BUBBLE is a single cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:    state_nxt = (hazard && !flush) ? ST_BUBBLE : ST_RUN;
      ST_BUBBLE: state_nxt = ST_RUN;
      default:   state_nxt = ST_RUN;
    endcase
  end

  // Outputs. In BUBBLE the load sits in MEM and EX is empty, so no hazard
  // can be seen; only a flush can turn that cycle into another bubble.
  always_comb begin
    stall_int   = 1'b0;
    load_bubble = flush;
    cnt_inc     = 1'b0;
    case (state)
      ST_RUN: begin
        if (hazard && !flush) begin
          stall_int   = 1'b1;
          load_bubble = 1'b1;
          cnt_inc     = 1'b1;
        end
      end
      default: begin
        stall_int = 1'b0;
      end
    endcase
  end

  assign stall_out = stall_int && rst_n;

  // EX register. A bubble clears the register numbers too, so the
  // forwarding unit can never match against an empty slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid   <= 1'b0;
      ex_rs      <= '0;
      ex_rt      <= '0;
      ex_rd      <= '0;
      ex_rs_data <= '0;
      ex_rt_data <= '0;
      ex_imm     <= '0;
      ex_ctrl    <= '0;
    end else if (load_bubble) begin
      ex_valid   <= 1'b0;
      ex_rs      <= '0;
      ex_rt      <= '0;
      ex_rd      <= '0;
      ex_rs_data <= '0;
      ex_rt_data <= '0;
      ex_imm     <= '0;
      ex_ctrl    <= '0;
    end else begin
      ex_valid   <= id_valid;
      ex_rs      <= id_rs;
      ex_rt      <= id_rt;
      ex_rd      <= id_rd;
      ex_rs_data <= id_rs_data;
      ex_rt_data <= id_rt_data;
      ex_imm     <= id_imm;
      ex_ctrl    <= id_ctrl;
    end
  end

  // Load-use bubble counter, saturating at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt <= '0;
    end else if (cnt_inc && (bubble_cnt != '1)) begin
      bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

  localparam int DW = 23;
  localparam int AW = 5;
  localparam int CW = 8;
  localparam int NW = 2;
  localparam int CNT_MAX = 3;

  // {RegWrite, MemRead, MemWrite, MemToReg, ALUSrc, ALUOp}
  localparam logic [CW-1:0] C_LW   = 8'b1101_1000;
  localparam logic [CW-1:0] C_ADD  = 8'b1000_0010;
  localparam logic [CW-1:0] C_ADDI = 8'b1000_1000;

  typedef struct packed {
    logic          v;
    logic [AW-1:0] rs;
    logic [AW-1:0] rt;
    logic [AW-1:0] rd;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] imm;
    logic [CW-1:0] ctrl;
  } ex_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          id_valid = 1'b0;
  logic [AW-1:0] id_rs = '0;
  logic [AW-1:0] id_rt = '0;
  logic [AW-1:0] id_rd = '0;
  logic          id_uses_rt = 1'b0;
  logic [DW-1:0] id_rs_data = '0;
  logic [DW-1:0] id_rt_data = '0;
  logic [DW-1:0] id_imm = '0;
  logic [CW-1:0] id_ctrl = '0;
  logic          flush = 1'b0;
  logic          ex_valid;
  logic [AW-1:0] ex_rs;
  logic [AW-1:0] ex_rt;
  logic [AW-1:0] ex_rd;
  logic [DW-1:0] ex_rs_data;
  logic [DW-1:0] ex_rt_data;
  logic [DW-1:0] ex_imm;
  logic [CW-1:0] ex_ctrl;
  logic          stall_out;
  logic [NW-1:0] bubble_cnt;

  ex_t act;
  assign act = {ex_valid, ex_rs, ex_rt, ex_rd, ex_rs_data, ex_rt_data, ex_imm, ex_ctrl};

  int n_assert = 0;
  int n_fail = 0;

  // Reference model: contents of the EX slot and the number of bubbles seen.
  ex_t m_ex = '0;
  int  m_cnt = 0;

  id_ex_stage #(
    .DATA_W (DW),
    .REG_AW (AW),
    .CTRL_W (CW),
    .CNT_W  (NW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .id_valid   (id_valid),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_rd      (id_rd),
    .id_uses_rt (id_uses_rt),
    .id_rs_data (id_rs_data),
    .id_rt_data (id_rt_data),
    .id_imm     (id_imm),
    .id_ctrl    (id_ctrl),
    .flush      (flush),
    .ex_valid   (ex_valid),
    .ex_rs      (ex_rs),
    .ex_rt      (ex_rt),
    .ex_rd      (ex_rd),
    .ex_rs_data (ex_rs_data),
    .ex_rt_data (ex_rt_data),
    .ex_imm     (ex_imm),
    .ex_ctrl    (ex_ctrl),
    .stall_out  (stall_out),
    .bubble_cnt (bubble_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  // A dependent instruction in ID is blocked only by a valid load in EX
  // that writes a non-zero register the instruction actually reads.
  function automatic bit model_hazard();
    bit reads_it;
    reads_it = (m_ex.rd == id_rs) || (id_uses_rt && (m_ex.rd == id_rt));
    return id_valid && m_ex.v && m_ex.ctrl[6] && (m_ex.rd != 0) && reads_it;
  endfunction

  function automatic bit model_stall();
    return model_hazard() && !flush;
  endfunction

  task automatic tick();
    bit h;
    h = model_hazard();
    if (flush || h) begin
      m_ex = '0;
    end else begin
      m_ex = '{v: id_valid, rs: id_rs, rt: id_rt, rd: id_rd, a: id_rs_data,
               b: id_rt_data, imm: id_imm, ctrl: id_ctrl};
    end
    if (h && !flush && m_cnt < CNT_MAX) m_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input bit v, input int rs, input int rt, input int rd,
                        input bit uses, input logic [CW-1:0] ctrl, input bit fl);
    id_valid   = v;
    id_rs      = AW'(rs);
    id_rt      = AW'(rt);
    id_rd      = AW'(rd);
    id_uses_rt = uses;
    id_ctrl    = ctrl;
    flush      = fl;
    id_rs_data = DW'($urandom());
    id_rt_data = DW'($urandom());
    id_imm     = DW'($urandom());
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    m_ex  = '0;
    m_cnt = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_id(1, 8, 9, 10, 1, C_LW, 0);
    repeat (3) @(posedge clk);
    #1;
    n_assert++;
    if (act !== '0) begin
      n_fail++;
      $display("FAIL reset_ex: got %h, required 0", act);
    end
    n_assert++;
    if (stall_out !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_stall: got %b, required 0", stall_out);
    end
    n_assert++;
    if (bubble_cnt !== '0) begin
      n_fail++;
      $display("FAIL reset_cnt: got %0d, required 0", bubble_cnt);
    end
    m_ex  = '0;
    m_cnt = 0;
    rst_n = 1'b1;
    set_id(1, 3, 4, 5, 1, C_ADD, 0);
    tick();
    n_assert++;
    if (act !== m_ex) begin
      n_fail++;
      $display("FAIL reset_first_load: got %h, required %h", act, m_ex);
    end
  endtask

  task automatic test_load_use();
    set_id(0, 0, 0, 0, 0, '0, 0);
    tick();
    set_id(1, 29, 8, 8, 0, C_LW, 0);
    tick();
    set_id(1, 8, 9, 10, 1, C_ADD, 0);
    n_assert++;
    if (stall_out !== 1'b1) begin
      n_fail++;
      $display("FAIL lu_stall: got %b, required 1", stall_out);
    end
    tick();
    n_assert++;
    if (ex_valid !== 1'b0 || ex_ctrl !== '0 || ex_rd !== '0 || ex_rs !== '0) begin
      n_fail++;
      $display("FAIL lu_bubble: got v=%b ctrl=%h rs=%0d rd=%0d, required all 0",
               ex_valid, ex_ctrl, ex_rs, ex_rd);
    end
    n_assert++;
    if (bubble_cnt !== NW'(1)) begin
      n_fail++;
      $display("FAIL lu_cnt: got %0d, required 1", bubble_cnt);
    end
    n_assert++;
    if (stall_out !== 1'b0) begin
      n_fail++;
      $display("FAIL lu_release: got %b, required 0", stall_out);
    end
    tick();
    n_assert++;
    if (ex_rs !== AW'(8) || ex_valid !== 1'b1 || act !== m_ex) begin
      n_fail++;
      $display("FAIL lu_reissue: got %h, required %h (rs=8 v=1)", act, m_ex);
    end
  endtask

  task automatic test_no_false_stall();
    set_id(1, 29, 8, 8, 0, C_LW, 0);
    tick();
    set_id(1, 3, 8, 8, 0, C_ADDI, 0);
    n_assert++;
    if (stall_out !== 1'b0) begin
      n_fail++;
      $display("FAIL nfs_rt_unused: got %b, required 0", stall_out);
    end
    tick();
    set_id(1, 29, 0, 0, 0, C_LW, 0);
    tick();
    set_id(1, 0, 0, 4, 1, C_ADD, 0);
    n_assert++;
    if (stall_out !== 1'b0) begin
      n_fail++;
      $display("FAIL nfs_reg0: got %b, required 0", stall_out);
    end
    tick();
    set_id(1, 1, 2, 8, 1, C_ADD, 0);
    tick();
    set_id(1, 8, 2, 9, 1, C_ADD, 0);
    n_assert++;
    if (stall_out !== 1'b0) begin
      n_fail++;
      $display("FAIL nfs_not_load: got %b, required 0", stall_out);
    end
    tick();
    set_id(1, 29, 8, 8, 0, C_LW, 0);
    tick();
    set_id(0, 8, 8, 9, 1, C_ADD, 0);
    n_assert++;
    if (stall_out !== 1'b0) begin
      n_fail++;
      $display("FAIL nfs_id_invalid: got %b, required 0", stall_out);
    end
    tick();
    n_assert++;
    if (act !== m_ex) begin
      n_fail++;
      $display("FAIL nfs_ex: got %h, required %h", act, m_ex);
    end
  endtask

  task automatic test_flush();
    int cnt_before;
    set_id(1, 29, 8, 8, 0, C_LW, 0);
    tick();
    cnt_before = m_cnt;
    set_id(1, 8, 9, 10, 1, C_ADD, 1);
    n_assert++;
    if (stall_out !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_stall: got %b, required 0", stall_out);
    end
    tick();
    n_assert++;
    if (ex_valid !== 1'b0 || int'(bubble_cnt) != cnt_before) begin
      n_fail++;
      $display("FAIL flush_bubble: got v=%b cnt=%0d, required v=0 cnt=%0d",
               ex_valid, bubble_cnt, cnt_before);
    end
    set_id(1, 29, 9, 9, 0, C_LW, 0);
    tick();
    set_id(1, 9, 2, 3, 1, C_ADD, 0);
    n_assert++;
    if (stall_out !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_then_run: got %b, required 1", stall_out);
    end
    tick();
    set_id(1, 9, 2, 3, 1, C_ADD, 0);
    tick();
  endtask

  task automatic test_reset_mid_stall();
    set_id(1, 29, 8, 8, 0, C_LW, 0);
    tick();
    set_id(1, 8, 9, 10, 1, C_ADD, 0);
    tick();
    // now in the bubble cycle
    rst_n = 1'b0;
    #1;
    n_assert++;
    if (act !== '0 || bubble_cnt !== '0 || stall_out !== 1'b0) begin
      n_fail++;
      $display("FAIL rms_clear: got ex=%h cnt=%0d stall=%b, required all 0",
               act, bubble_cnt, stall_out);
    end
    m_ex  = '0;
    m_cnt = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    set_id(1, 29, 5, 5, 0, C_LW, 0);
    tick();
    set_id(1, 5, 6, 7, 1, C_ADD, 0);
    n_assert++;
    if (stall_out !== 1'b1) begin
      n_fail++;
      $display("FAIL rms_run: got %b, required 1", stall_out);
    end
    tick();
    n_assert++;
    if (bubble_cnt !== NW'(1)) begin
      n_fail++;
      $display("FAIL rms_cnt: got %0d, required 1", bubble_cnt);
    end
    set_id(1, 5, 6, 7, 1, C_ADD, 0);
    tick();
  endtask

  task automatic test_saturation();
    int exp_cnt [5] = '{1, 2, 3, 3, 3};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_id(1, 29, 7, 7, 0, C_LW, 0);
      tick();
      set_id(1, 1, 7, 11, 1, C_ADD, 0);
      tick();
      n_assert++;
      if (int'(bubble_cnt) != exp_cnt[i]) begin
        n_fail++;
        $display("FAIL sat_cnt[%0d]: got %0d, required %0d", i, bubble_cnt, exp_cnt[i]);
      end
      set_id(1, 1, 7, 11, 1, C_ADD, 0);
      tick();
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      set_id($urandom_range(0, 9) < 8,
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 1),
             ($urandom_range(0, 1) != 0) ? C_LW : CW'($urandom()),
             $urandom_range(0, 9) == 0);
      n_assert++;
      if (stall_out !== model_stall()) begin
        n_fail++;
        $display("FAIL rnd_stall[%0d]: got %b, required %b", i, stall_out, model_stall());
      end
      tick();
      n_assert++;
      if (act !== m_ex || int'(bubble_cnt) != m_cnt) begin
        n_fail++;
        $display("FAIL rnd_ex[%0d]: got %h cnt=%0d, required %h cnt=%0d",
                 i, act, bubble_cnt, m_ex, m_cnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_no_false_stall();
    test_flush();
    test_reset_mid_stall();
    test_saturation();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
